// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, derived sync windows and
// the position / raster-signal types used by vga_timing_gen and its delay line.
package vga_timing_pkg;

    // Default 640x480@60 geometry (pixel clock 25.175 MHz)
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    // Sync windows, inclusive on both ends
    localparam int HS_START = H_ACTIVE + H_FP;                   // 656
    localparam int HS_END   = HS_START + H_SYNC - 1;             // 751
    localparam int VS_START = V_ACTIVE + V_FP;                   // 490
    localparam int VS_END   = VS_START + V_SYNC - 1;             // 491

    localparam int PIPE_DLY_DEF = 2;

    localparam int POS_W = 10;
    typedef logic [POS_W-1:0] pos_t;

    // Per-pixel raster signals that travel together through the optional delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
        logic line_start;
        logic frame_start;
    } raster_sig_t;

    localparam int SIG_W = $bits(raster_sig_t);

    // Inactive levels: syncs idle high, everything else low
    localparam raster_sig_t SIG_IDLE = '{
        hsync:       1'b1,
        vsync:       1'b1,
        display_on:  1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    // Last legal position of a counter that runs 0..total-1
    function automatic pos_t last_pos(input int total);
        return pos_t'(total - 1);
    endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// vga_sig_delay: WIDTH x DEPTH shift register, advancing only when i_ce is high,
// with every stage reset to RST_VAL. DEPTH of 0 is a plain wire.
module vga_sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] r_q;
                logic [WIDTH-1:0] w_d;

                if (gi == 0) begin : g_head
                    assign w_d = i_d;
                end else begin : g_link
                    assign w_d = g_stage[gi-1].r_q;
                end

                // One stage: load from the previous stage on pixel-enable cycles
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_q <= RST_VAL;
                    end else if (i_ce) begin
                        r_q <= w_d;
                    end
                end
            end
            assign o_q = g_stage[DEPTH-1].r_q;
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing source (hpos/vpos, active-low syncs,
// display_on, line/frame strobes, 16-bit frame counter), advanced by pix_ce.
// Optional feature: define VGA_SYNC_DELAY_EN to delay hsync, vsync, display_on,
// line_start and frame_start by PIPE_DLY pixel-enable stages (positions and
// frame_count are never delayed).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int PIPE_DLY = vga_timing_pkg::PIPE_DLY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    output logic [POS_W-1:0]  hpos,
    output logic [POS_W-1:0]  vpos,
    output logic              hsync,
    output logic              vsync,
    output logic              display_on,
    output logic              line_start,
    output logic              frame_start,
    output logic [15:0]       frame_count
);

    // Elaboration-time constants; the datapath only ever compares and adds 1
    localparam pos_t H_LAST   = last_pos(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam pos_t V_LAST   = last_pos(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam pos_t HS_FIRST = pos_t'(H_ACTIVE + H_FP);
    localparam pos_t HS_LAST  = pos_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam pos_t VS_FIRST = pos_t'(V_ACTIVE + V_FP);
    localparam pos_t VS_LAST  = pos_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam pos_t H_VIS    = pos_t'(H_ACTIVE);
    localparam pos_t V_VIS    = pos_t'(V_ACTIVE);

    pos_t        r_hpos;
    pos_t        r_vpos;
    logic [15:0] r_frame_count;
    raster_sig_t r_sig;
    logic        r_ce_q;

    pos_t        w_hpos_next;
    pos_t        w_vpos_next;
    logic        w_line_wrap;
    logic        w_frame_wrap;
    raster_sig_t w_sig_next;
    raster_sig_t w_sig_out;

    // Next raster position and the wrap events it causes
    always_comb begin
        w_hpos_next  = r_hpos;
        w_vpos_next  = r_vpos;
        w_line_wrap  = 1'b0;
        w_frame_wrap = 1'b0;
        if (pix_ce) begin
            if (r_hpos == H_LAST) begin
                w_hpos_next = '0;
                w_line_wrap = 1'b1;
                if (r_vpos == V_LAST) begin
                    w_vpos_next  = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_vpos_next = r_vpos + pos_t'(1);
                end
            end else begin
                w_hpos_next = r_hpos + pos_t'(1);
            end
        end
    end

    // Raster signals decoded from the next position so they line up with hpos/vpos
    always_comb begin
        w_sig_next = r_sig;
        if (pix_ce) begin
            w_sig_next.hsync       = !((w_hpos_next >= HS_FIRST) && (w_hpos_next <= HS_LAST));
            w_sig_next.vsync       = !((w_vpos_next >= VS_FIRST) && (w_vpos_next <= VS_LAST));
            w_sig_next.display_on  = (w_hpos_next < H_VIS) && (w_vpos_next < V_VIS);
            w_sig_next.line_start  = w_line_wrap;
            w_sig_next.frame_start = w_frame_wrap;
        end
    end

    // Counter, frame counter and decoded-signal registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_frame_count <= '0;
            r_sig         <= SIG_IDLE;
            r_ce_q        <= 1'b0;
        end else begin
            r_hpos <= w_hpos_next;
            r_vpos <= w_vpos_next;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            r_sig  <= w_sig_next;
            // Strobes only count on the cycle right after a pixel-enable edge
            r_ce_q <= pix_ce;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    vga_sig_delay #(
        .WIDTH   (SIG_W),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SIG_IDLE)
    ) u_sig_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ce  (pix_ce),
        .i_d   (r_sig),
        .o_q   (w_sig_out)
    );
`else
    generate
        // Zero-delay build: PIPE_DLY has no effect; a negative value parks outputs idle
        if (PIPE_DLY >= 0) begin : g_direct
            assign w_sig_out = r_sig;
        end else begin : g_parked
            assign w_sig_out = SIG_IDLE;
        end
    endgenerate
`endif

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign frame_count = r_frame_count;
    assign hsync       = w_sig_out.hsync;
    assign vsync       = w_sig_out.vsync;
    assign display_on  = w_sig_out.display_on;
    // Strobe registers hold across ce-low gaps; mask them so they last one ce cycle
    assign line_start  = w_sig_out.line_start  & r_ce_q;
    assign frame_start = w_sig_out.frame_start & r_ce_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors, directed raster sequences and randomized
// reset / pix_ce stimulus checked against an arithmetic raster model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam logic [4:0] IDLE = 5'b11000;   // hsync, vsync, display_on, line_start, frame_start
    localparam logic       E1   = (DLY == 0); // display_on right after the first ce edges

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pix_ce = 1'b0;
    logic [9:0]  hpos, vpos;
    logic        hsync, vsync, display_on, line_start, frame_start;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         m_h, m_v, m_fc;
    logic [4:0] m_r, m_s1, m_s2;
    logic       m_ceq;

    // Preload values used with force
    logic [9:0]  pl_h, pl_v;
    logic [15:0] pl_fc;

    typedef struct {
        logic       rst_n;
        logic       ce;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       disp;
        logic       ls;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    vga_timing_gen #(.PIPE_DLY(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_word();
        return 64'({hpos, vpos, frame_count, hsync, vsync, display_on, line_start, frame_start});
    endfunction

    function automatic logic [63:0] model_word();
        logic [4:0] src;
        logic [4:0] e;
        src = (DLY != 0) ? m_s2 : m_r;
        e   = {src[4:2], src[1:0] & {2{m_ceq}}};
        return 64'({m_h[9:0], m_v[9:0], m_fc[15:0], e});
    endfunction

    // Raster rules applied at one clock edge
    task automatic model_edge(input logic r, input logic ce);
        logic ls, fs;
        if (!r) begin
            m_h = 0; m_v = 0; m_fc = 0;
            m_r = IDLE; m_s1 = IDLE; m_s2 = IDLE;
            m_ceq = 1'b0;
        end else begin
            m_ceq = ce;
            if (ce) begin
                m_s2 = m_s1;
                m_s1 = m_r;
                ls = (m_h == H_TOTAL - 1);
                fs = ls && (m_v == V_TOTAL - 1);
                m_h = (m_h + 1) % H_TOTAL;
                if (ls) m_v = (m_v + 1) % V_TOTAL;
                if (fs) m_fc = (m_fc + 1) % 65536;
                m_r[4] = !((m_h >= HS_START) && (m_h <= HS_END));
                m_r[3] = !((m_v >= VS_START) && (m_v <= VS_END));
                m_r[2] = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
                m_r[1] = ls;
                m_r[0] = fs;
            end
        end
    endtask

    task automatic step(input logic r, input logic ce);
        rst_n  = r;
        pix_ce = ce;
        @(posedge clk);
        model_edge(r, ce);
        #1;
        check("model", dut_word(), model_word());
    endtask

    task automatic preload(input int h, input int v, input int fc);
        pl_h  = 10'(h);
        pl_v  = 10'(v);
        pl_fc = 16'(fc);
        force dut.r_hpos        = pl_h;
        force dut.r_vpos        = pl_v;
        force dut.r_frame_count = pl_fc;
        #1;
        release dut.r_hpos;
        release dut.r_vpos;
        release dut.r_frame_count;
        m_h = h; m_v = v; m_fc = fc;
    endtask

    initial begin
        int lows, first_low, ls_cnt, fs_cnt, fall_h, fs_h, fs_v, vs_v, vs_h;
        logic seen_on;

        m_h = 0; m_v = 0; m_fc = 0;
        m_r = IDLE; m_s1 = IDLE; m_s2 = IDLE; m_ceq = 1'b0;

        // Reset state, hold, first ce steps, reset again
        tbl[0] = '{rst_n:1'b0, ce:1'b1, h:10'd0, v:10'd0, hs:1'b1, disp:1'b0, ls:1'b0, fc:16'd0};
        tbl[1] = '{rst_n:1'b1, ce:1'b0, h:10'd0, v:10'd0, hs:1'b1, disp:1'b0, ls:1'b0, fc:16'd0};
        tbl[2] = '{rst_n:1'b1, ce:1'b1, h:10'd1, v:10'd0, hs:1'b1, disp:E1,   ls:1'b0, fc:16'd0};
        tbl[3] = '{rst_n:1'b1, ce:1'b1, h:10'd2, v:10'd0, hs:1'b1, disp:E1,   ls:1'b0, fc:16'd0};
        tbl[4] = '{rst_n:1'b1, ce:1'b0, h:10'd2, v:10'd0, hs:1'b1, disp:E1,   ls:1'b0, fc:16'd0};
        tbl[5] = '{rst_n:1'b0, ce:1'b1, h:10'd0, v:10'd0, hs:1'b1, disp:1'b0, ls:1'b0, fc:16'd0};
        tbl[6] = '{rst_n:1'b1, ce:1'b1, h:10'd1, v:10'd0, hs:1'b1, disp:E1,   ls:1'b0, fc:16'd0};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst_n, tbl[i].ce);
            check($sformatf("vec%0d", i), dut_word(),
                  64'({tbl[i].h, tbl[i].v, tbl[i].fc, tbl[i].hs, 1'b1, tbl[i].disp, tbl[i].ls, 1'b0}));
        end

        // One full line from reset
        step(1'b0, 1'b1);
        lows = 0; first_low = -1; ls_cnt = 0; fall_h = -1; seen_on = 1'b0;
        for (int i = 0; i < 800 + DLY; i++) begin
            step(1'b1, 1'b1);
            if (!hsync) begin
                lows++;
                if (first_low < 0) first_low = int'(hpos);
            end
            if (display_on) seen_on = 1'b1;
            else if (seen_on && fall_h < 0) fall_h = int'(hpos);
            if (line_start) begin
                ls_cnt++;
                check("line_start_hpos", 64'(hpos), 64'(DLY));
            end
        end
        check("line_end_hpos", 64'(hpos), 64'(DLY));
        check("line_end_vpos", 64'(vpos), 64'd1);
        check("hsync_low_cycles", 64'(lows), 64'd96);
        check("hsync_fall_hpos", 64'(first_low), 64'(656 + DLY));
        check("display_fall_hpos", 64'(fall_h), 64'(640 + DLY));
        check("line_start_count", 64'(ls_cnt), 64'd1);

        // pix_ce toggling 1,0 for 1600 clocks: 800 steps, strobes only on ce cycles
        for (int i = 0; i < 1600; i++) begin
            step(1'b1, (i % 2) == 0);
            if (!pix_ce) check("strobe_while_ce0", 64'({line_start, frame_start}), 64'd0);
        end
        check("toggle_hpos", 64'(hpos), 64'(DLY));
        check("toggle_vpos", 64'(vpos), 64'd2);

        // Vertical sync window
        preload(799, 488, 0);
        lows = 0; vs_v = -1; vs_h = -1;
        for (int i = 0; i < 3200; i++) begin
            step(1'b1, 1'b1);
            if (!vsync) begin
                lows++;
                if (vs_v < 0) begin
                    vs_v = int'(vpos);
                    vs_h = int'(hpos);
                end
            end
        end
        check("vsync_low_cycles", 64'(lows), 64'd1600);
        check("vsync_fall_vpos", 64'(vs_v), 64'd490);
        check("vsync_fall_hpos", 64'(vs_h), 64'(DLY));

        // End of frame 0
        preload(790, 524, 0);
        fs_cnt = 0; fs_h = -1; fs_v = -1;
        for (int i = 0; i < 12 + DLY; i++) begin
            step(1'b1, 1'b1);
            if (frame_start) begin
                fs_cnt++;
                fs_h = int'(hpos);
                fs_v = int'(vpos);
            end
        end
        check("frame_start_count", 64'(fs_cnt), 64'd1);
        check("frame_start_hpos", 64'(fs_h), 64'(DLY));
        check("frame_start_vpos", 64'(fs_v), 64'd0);
        check("frame_count_one", 64'(frame_count), 64'd1);

        // Frame counter wrap 0xFFFF -> 0
        preload(795, 524, 'hFFFF);
        fs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            if (frame_start) fs_cnt++;
        end
        check("wrap_frame_start", 64'(fs_cnt), 64'd1);
        check("wrap_frame_count", 64'(frame_count), 64'd0);

        // Reset mid-frame at hpos=300, vpos=200
        preload(299, 200, 7);
        step(1'b1, 1'b1);
        check("mid_pos_before", 64'({hpos, vpos, frame_count}), 64'({10'd300, 10'd200, 16'd7}));
        step(1'b0, 1'b1);
        check("mid_reset", 64'({hpos, vpos, display_on, hsync, frame_count}),
              64'({10'd0, 10'd0, 1'b0, 1'b1, 16'd0}));

        // Randomized reset and pix_ce
        for (int i = 0; i < 20000; i++) begin
            step($urandom_range(0, 2999) != 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
